// File: rtl/servo_pwm_channel_if.sv
// ------------------------------------------------------------------
// servo_pwm_channel_if : control/status bundle of one servo PWM channel
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface servo_pwm_channel_if;
   logic       load;
   logic [7:0] data;
   logic       enable;
   logic       pwm;
   logic       frame_start;
   logic [7:0] position;
   logic       pending;

   modport master (
      output load, data, enable,
      input  pwm, frame_start, position, pending
   );

   modport slave (
      input  load, data, enable,
      output pwm, frame_start, position, pending
   );
endinterface

`default_nettype wire

// File: rtl/servo_pwm_channel.sv
// ------------------------------------------------------------------
// servo_pwm_channel : RC servo pulse generator with shadowed position
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module servo_pwm_channel #(
   parameter int unsigned PRESCALE    = 195,
   parameter int unsigned MIN_TICKS   = 256,
   parameter int unsigned FRAME_TICKS = 5120
) (
   input  logic               clk,
   input  logic               rst_n,
   servo_pwm_channel_if.slave bus
);

   localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned TICK_W = $clog2(FRAME_TICKS);

   localparam logic [PRE_W-1:0]  c_pre_last   = PRE_W'(PRESCALE - 1);
   localparam logic [PRE_W-1:0]  c_pre_one    = PRE_W'(1);
   localparam logic [TICK_W-1:0] c_frame_last = TICK_W'(FRAME_TICKS - 1);
   localparam logic [TICK_W-1:0] c_min        = TICK_W'(MIN_TICKS);
   localparam logic [TICK_W-1:0] c_tick_one   = TICK_W'(1);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_high = 2'd1;
   localparam logic [1:0] c_st_low  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [TICK_W-1:0] tcnt_q, tcnt_d;
   logic [7:0]        shadow_q, shadow_d;
   logic [7:0]        position_q, position_d;
   logic              pending_q, pending_d;
   logic              load_prev_q;
   logic              pwm_q, pwm_d;
   logic              frame_start_q, frame_start_d;

   logic              w_tick;
   logic              w_boundary;
   logic              w_high_end;
   logic              w_load_edge;
   logic              w_frame_go;
   logic [TICK_W-1:0] w_high_last;

   // Counter width covers FRAME_TICKS-1, which bounds MIN_TICKS+255.
   assign w_high_last = c_min + TICK_W'(position_q) - c_tick_one;
   assign w_tick      = (presc_q == c_pre_last);
   assign w_boundary  = w_tick && (tcnt_q == c_frame_last);
   assign w_high_end  = w_tick && (tcnt_q == w_high_last);
   assign w_load_edge = bus.load && !load_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= c_st_idle;
         presc_q       <= '0;
         tcnt_q        <= '0;
         shadow_q      <= '0;
         position_q    <= '0;
         pending_q     <= 1'b0;
         load_prev_q   <= 1'b0;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         tcnt_q        <= tcnt_d;
         shadow_q      <= shadow_d;
         position_q    <= position_d;
         pending_q     <= pending_d;
         load_prev_q   <= bus.load;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Enable is only looked at in IDLE and on the frame boundary.
   always_comb begin
      state_d    = state_q;
      w_frame_go = 1'b0;
      case (state_q)
         c_st_idle: begin
            if (bus.enable) begin
               state_d    = c_st_high;
               w_frame_go = 1'b1;
            end
         end
         c_st_high, c_st_low: begin
            if (w_boundary) begin
               if (bus.enable) begin
                  state_d    = c_st_high;
                  w_frame_go = 1'b1;
               end else begin
                  state_d = c_st_idle;
               end
            end else if ((state_q == c_st_high) && w_high_end) begin
               state_d = c_st_low;
            end
         end
         default: state_d = c_st_idle;
      endcase
   end

   always_comb begin
      presc_d       = presc_q;
      tcnt_d        = tcnt_q;
      shadow_d      = shadow_q;
      position_d    = position_q;
      pending_d     = pending_q;
      if (state_q == c_st_idle) begin
         presc_d = '0;
         tcnt_d  = '0;
      end else begin
         presc_d = w_tick ? '0 : presc_q + c_pre_one;
         if (w_tick) begin
            tcnt_d = (tcnt_q == c_frame_last) ? '0 : tcnt_q + c_tick_one;
         end
      end
      if (w_frame_go && pending_q) begin
         position_d = shadow_q;
         pending_d  = 1'b0;
      end
      // A capture on the frame-start edge lands in shadow for the next frame.
      if (w_load_edge) begin
         shadow_d  = bus.data;
         pending_d = 1'b1;
      end
      pwm_d         = (state_d == c_st_high);
      frame_start_d = w_frame_go;
   end

   assign bus.pwm         = pwm_q;
   assign bus.frame_start = frame_start_q;
   assign bus.position    = position_q;
   assign bus.pending     = pending_q;

endmodule

`default_nettype wire
